// File: rtl/confreg_defs.sv
// Register map and field positions for the sram-port configuration block.
package confreg_defs;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 6;

    localparam logic [OFF_W-1:0] CR_SCRATCH0 = 6'h00;
    localparam logic [OFF_W-1:0] CR_SCRATCH1 = 6'h01;
    localparam logic [OFF_W-1:0] CR_LED      = 6'h02;
    localparam logic [OFF_W-1:0] CR_SWITCH   = 6'h03;
    localparam logic [OFF_W-1:0] CR_TIMER    = 6'h04;
    localparam logic [OFF_W-1:0] CR_COMPARE  = 6'h05;
    localparam logic [OFF_W-1:0] CR_STATUS   = 6'h06;
    localparam logic [OFF_W-1:0] CR_CTRL     = 6'h07;

    localparam int unsigned STATUS_PEND_BIT = 0;
    localparam int unsigned CTRL_TEN_BIT    = 0;
    localparam int unsigned CTRL_IE_BIT     = 1;

    localparam logic [DATA_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First flop may go metastable; second flop gives a settled copy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sram_confreg.sv
// Configuration/peripheral registers on the CPU sram-style data port:
// scratch, LEDs, synchronised switches, timer with compare interrupt.
module sram_confreg
    import confreg_defs::*;
#(
    parameter int unsigned LED_W = 16,
    parameter int unsigned SW_W  = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [3:0]       wen,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw,
    output logic             irq
);

    logic [DATA_W-1:0] scratch0;
    logic [DATA_W-1:0] scratch1;
    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] compare;
    logic              pend;
    logic              ten;
    logic              ie;
    logic [SW_W-1:0]   sw_sync;

    logic [OFF_W-1:0]  off_c;
    logic              wr_c;
    logic              rd_c;
    logic              match_c;
    logic              clr_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              unused_addr_c;

    // Replace only the byte lanes whose write enable is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [3:0]        lanes
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    sync_2ff #(.W(SW_W)) u_sw_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (sw),
        .q      (sw_sync)
    );

    assign off_c         = addr[7:2];
    assign unused_addr_c = ^{addr[31:8], addr[1:0]};
    assign wr_c          = en & (|wen);
    assign rd_c          = en & ~(|wen);

    // Match and clear are judged on pre-update register values.
    assign match_c = ten & (timer == compare);
    assign clr_c   = wr_c & (off_c == CR_STATUS) & wen[0] & wdata[STATUS_PEND_BIT];

    // Read mux over current register contents.
    always_comb begin
        rd_mux_c = '0;
        case (off_c)
            CR_SCRATCH0: rd_mux_c = scratch0;
            CR_SCRATCH1: rd_mux_c = scratch1;
            CR_LED:      rd_mux_c = DATA_W'(led);
            CR_SWITCH:   rd_mux_c = DATA_W'(sw_sync);
            CR_TIMER:    rd_mux_c = timer;
            CR_COMPARE:  rd_mux_c = compare;
            CR_STATUS:   rd_mux_c[STATUS_PEND_BIT] = pend;
            CR_CTRL: begin
                rd_mux_c[CTRL_TEN_BIT] = ten;
                rd_mux_c[CTRL_IE_BIT]  = ie;
            end
            default:     rd_mux_c = '0;
        endcase
    end

    // Plain RW registers with byte-lane writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scratch0 <= '0;
            scratch1 <= '0;
            led      <= '0;
            compare  <= COMPARE_RST;
            ten      <= 1'b0;
            ie       <= 1'b0;
        end else if (wr_c) begin
            case (off_c)
                CR_SCRATCH0: scratch0 <= merge_bytes(scratch0, wdata, wen);
                CR_SCRATCH1: scratch1 <= merge_bytes(scratch1, wdata, wen);
                CR_LED:      led      <= LED_W'(merge_bytes(DATA_W'(led), wdata, wen));
                CR_COMPARE:  compare  <= merge_bytes(compare, wdata, wen);
                CR_CTRL: begin
                    if (wen[0]) begin
                        ten <= wdata[CTRL_TEN_BIT];
                        ie  <= wdata[CTRL_IE_BIT];
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running timer; a write overrides that cycle's increment.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer <= '0;
        end else if (wr_c && (off_c == CR_TIMER)) begin
            timer <= merge_bytes(timer, wdata, wen);
        end else if (ten) begin
            timer <= timer + 32'd1;
        end
    end

    // Pending flag (set wins over clear) and registered interrupt level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend <= 1'b0;
            irq  <= 1'b0;
        end else begin
            pend <= match_c | (pend & ~clr_c);
            irq  <= pend & ie;
        end
    end

    // Read data captured on read requests, held otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (rd_c) begin
            rdata <= rd_mux_c;
        end
    end

endmodule
